// File: rtl/booth_seq_mult_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier:
// default widths, controller states and the Booth window codes.
package booth_seq_mult_pkg;

    localparam int MCAND_W_DEF = 25;
    localparam int MPLR_W_DEF  = 24;
    localparam int PROD_W_DEF  = MCAND_W_DEF + MPLR_W_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Window is {b[2i+1], b[2i], b[2i-1]} of the multiplier
    localparam logic [2:0] B_ZERO_L = 3'b000;
    localparam logic [2:0] B_P1_A   = 3'b001;
    localparam logic [2:0] B_P1_B   = 3'b010;
    localparam logic [2:0] B_P2     = 3'b011;
    localparam logic [2:0] B_M2     = 3'b100;
    localparam logic [2:0] B_M1_A   = 3'b101;
    localparam logic [2:0] B_M1_B   = 3'b110;
    localparam logic [2:0] B_ZERO_H = 3'b111;

endpackage

// File: rtl/booth_pp_sel.sv
// Combinational radix-4 Booth partial-product selector: maps a 3-bit
// multiplier window to 0, +/-M or +/-2M of the signed multiplicand.
module booth_pp_sel
    import booth_seq_mult_pkg::*;
#(
    parameter int MCAND_W = MCAND_W_DEF
) (
    input  logic        [2:0]         win_i,
    input  logic signed [MCAND_W-1:0] mcand_i,
    output logic signed [MCAND_W+1:0] pp_o
);

    logic signed [MCAND_W+1:0] m1;
    logic signed [MCAND_W+1:0] m2;

    // Two guard bits keep -2M exact even for the most negative multiplicand
    assign m1 = (MCAND_W+2)'(mcand_i);
    assign m2 = m1 <<< 1;

    always_comb begin
        pp_o = '0;
        case (win_i)
            B_P1_A, B_P1_B: pp_o = m1;
            B_P2:           pp_o = m2;
            B_M2:           pp_o = -m2;
            B_M1_A, B_M1_B: pp_o = -m1;
            default:        pp_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: retires one window per cycle into a
// full-width signed accumulator and hands the product out over valid/ready.
module booth_seq_mult
    import booth_seq_mult_pkg::*;
#(
    parameter  int MCAND_W = MCAND_W_DEF,
    parameter  int MPLR_W  = MPLR_W_DEF,
    localparam int NWIN    = MPLR_W / 2,
    localparam int PROD_W  = MCAND_W + MPLR_W,
    localparam int CNT_W   = $clog2(NWIN + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [MCAND_W-1:0] mcand,
    input  logic signed [MPLR_W-1:0]  mplr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [PROD_W-1:0]  prod,
    output logic                      busy
);

    state_e                    state_q, state_d;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [MCAND_W-1:0] mcand_q, mcand_d;
    logic        [MPLR_W:0]    mplr_q, mplr_d;
    logic signed [PROD_W-1:0]  acc_q, acc_d;
    logic                      ovld_q, ovld_d;

    logic signed [MCAND_W+1:0] pp;
    logic signed [PROD_W-1:0]  pp_ext;
    logic signed [PROD_W-1:0]  pp_sh;

    // mplr_q holds the multiplier with b[-1]=0 appended and is shifted right by
    // two each RUN cycle, so bits [2:0] are always the current window.
    booth_pp_sel #(
        .MCAND_W (MCAND_W)
    ) u_pp_sel (
        .win_i   (mplr_q[2:0]),
        .mcand_i (mcand_q),
        .pp_o    (pp)
    );

    assign pp_ext = PROD_W'(pp);
    assign pp_sh  = pp_ext <<< {cnt_q, 1'b0};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        ovld_d  = ovld_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = mcand;
                    mplr_d  = {mplr, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d  = acc_q + pp_sh;
                mplr_d = {2'b00, mplr_q[MPLR_W:2]};
                if (cnt_q == CNT_W'(NWIN - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // First DONE cycle only raises out_valid; the handshake is honoured after that
                if (!ovld_q) begin
                    ovld_d = 1'b1;
                end else if (out_ready) begin
                    ovld_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ovld_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            ovld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            ovld_q  <= ovld_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = ovld_q;
    assign prod      = acc_q;

endmodule
